// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bus of the sequential restoring divider.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one shift/subtract step per clock behind a start/done handshake.
// Optional macro SIGNED_DIV_EN: two's-complement operands via magnitude division and sign fix-up.
module seq_restoring_divider #(
    parameter int WIDTH = 6
) (
    input logic                   clk,
    input logic                   rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   t_s;
    logic [WIDTH+1:0] sub_s;
    logic             ge_s;
    logic [WIDTH:0]   r_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH-1:0] q_res_s, r_res_s, z_rem_s;

    // Ripple-borrow subtractor a - b; MSB of the result is the carry-out (1 means a >= b).
    function automatic logic [WIDTH+1:0] ripple_sub(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic           c;
        logic [WIDTH:0] s;
        c = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            s[i] = a[i] ^ ~b[i] ^ c;
            c    = (a[i] & ~b[i]) | (a[i] & c) | (~b[i] & c);
        end
        return {c, s};
    endfunction

    assign t_s      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign sub_s    = ripple_sub(t_s, {1'b0, d_q});
    assign ge_s     = sub_s[WIDTH+1];
    assign r_step_s = ge_s ? sub_s[WIDTH:0] : t_s;
    assign q_step_s = {q_q[WIDTH-2:0], ge_s};

`ifdef SIGNED_DIV_EN
    logic neg_q_q, neg_r_q;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    assign a_mag_s = cond_neg(bus.dividend, bus.dividend[WIDTH-1]);
    assign b_mag_s = cond_neg(bus.divisor, bus.divisor[WIDTH-1]);
    assign q_res_s = cond_neg(q_step_s, neg_q_q);
    assign r_res_s = cond_neg(r_step_s[WIDTH-1:0], neg_r_q);
    assign z_rem_s = cond_neg(q_q, neg_r_q);

    // Result sign flags, captured with the operands on the accepted start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (state_q == IDLE && bus.start) begin
            neg_q_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r_q <= bus.dividend[WIDTH-1];
        end else begin
            neg_q_q <= neg_q_q;
            neg_r_q <= neg_r_q;
        end
    end
`else
    assign a_mag_s = bus.dividend;
    assign b_mag_s = bus.divisor;
    assign q_res_s = q_step_s;
    assign r_res_s = r_step_s[WIDTH-1:0];
    assign z_rem_s = q_q;
`endif

    // Next-state, datapath step and DONE-entry result registration.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // A zero divisor spends one idle step in CALC so results land on the same DONE-entry edge.
                    q_d     = a_mag_s;
                    d_d     = b_mag_s;
                    r_d     = {(WIDTH+1){1'b0}};
                    zero_d  = (bus.divisor == {WIDTH{1'b0}});
                    count_d = zero_d ? CW'(1) : CW'(WIDTH);
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                count_d = count_q - CW'(1);
                if (zero_q) begin
                    q_d = q_q;
                    r_d = r_q;
                end else begin
                    q_d = q_step_s;
                    r_d = r_step_s;
                end
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                    if (zero_q) begin
                        quot_d = {WIDTH{1'b1}};
                        rem_d  = z_rem_s;
                        dbz_d  = 1'b1;
                    end else begin
                        quot_d = q_res_s;
                        rem_d  = r_res_s;
                        dbz_d  = 1'b0;
                    end
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= {CW{1'b0}};
            q_q     <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            r_q     <= {(WIDTH+1){1'b0}};
            zero_q  <= 1'b0;
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: vector table plus scoreboard of expected results.
module tb_seq_restoring_divider;
    localparam int W = 6;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   done_cnt;
    int   d0;
    exp_t sb[$];
    exp_t sb_e;
    vec_t vt[$];

`ifdef SIGNED_DIV_EN
    localparam logic [W-1:0] HA = 6'd27, HB = 6'd7, HQ = 6'd3, HR = 6'd6;
    localparam logic [W-1:0] RA = 6'd25, RB = 6'd6, RQ = 6'd4, RR = 6'd1;
`else
    localparam logic [W-1:0] HA = 6'd45, HB = 6'd7, HQ = 6'd6, HR = 6'd3;
    localparam logic [W-1:0] RA = 6'd50, RB = 6'd6, RQ = 6'd8, RR = 6'd2;
`endif

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                sb_e = sb.pop_front();
                chk("quotient", int'(bus.quotient), int'(sb_e.q));
                chk("remainder", int'(bus.remainder), int'(sb_e.r));
                chk("div_by_zero", int'(bus.div_by_zero), int'(sb_e.z));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
    endtask

    // Waits for done after an accept edge; optionally pulses a second start at cycle inj_k.
    task automatic wait_done(input int exp_lat, input int inj_k);
        int k;
        bit seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == inj_k) begin
                bus.start    = 1'b1;
                bus.dividend = 6'd9;
                bus.divisor  = 6'd2;
            end else begin
                bus.start = 1'b0;
            end
            chk("busy_during_op", int'(bus.busy), 1);
            if (bus.done) seen = 1'b1;
        end
        chk("latency", seen ? k : -1, exp_lat);
        @(negedge clk);
        chk("done_one_cycle", int'(bus.done), 0);
        chk("busy_after_done", int'(bus.busy), 0);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_done"}, int'(bus.done), 0);
        chk({nm, "_quotient"}, int'(bus.quotient), 0);
        chk({nm, "_remainder"}, int'(bus.remainder), 0);
        chk({nm, "_dbz"}, int'(bus.div_by_zero), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks       = 0;
        passes       = 0;
        done_cnt     = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef SIGNED_DIV_EN
        vt.push_back('{6'b101100, 6'd3,      6'b111010, 6'b111110, 1'b0});
        vt.push_back('{6'd20,     6'b111101, 6'b111010, 6'd2,      1'b0});
        vt.push_back('{6'b100000, 6'b111111, 6'b100000, 6'd0,      1'b0});
        vt.push_back('{6'b111001, 6'b111110, 6'd3,      6'b111111, 1'b0});
        vt.push_back('{6'd7,      6'd2,      6'd3,      6'd1,      1'b0});
        vt.push_back('{6'd20,     6'd0,      6'b111111, 6'd20,     1'b1});
        vt.push_back('{6'b101100, 6'd0,      6'b111111, 6'b101100, 1'b1});
        vt.push_back('{6'd20,     6'd4,      6'd5,      6'd0,      1'b0});
`else
        vt.push_back('{6'd45, 6'd7,  6'd6,  6'd3,  1'b0});
        vt.push_back('{6'd63, 6'd1,  6'd63, 6'd0,  1'b0});
        vt.push_back('{6'd5,  6'd9,  6'd0,  6'd5,  1'b0});
        vt.push_back('{6'd0,  6'd13, 6'd0,  6'd0,  1'b0});
        vt.push_back('{6'd62, 6'd5,  6'd12, 6'd2,  1'b0});
        vt.push_back('{6'd63, 6'd63, 6'd1,  6'd0,  1'b0});
        vt.push_back('{6'd1,  6'd63, 6'd0,  6'd1,  1'b0});
        vt.push_back('{6'd20, 6'd0,  6'd63, 6'd20, 1'b1});
        vt.push_back('{6'd20, 6'd4,  6'd5,  6'd0,  1'b0});
`endif
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            sb.push_back('{vt[i].q, vt[i].r, vt[i].z});
            issue(vt[i].a, vt[i].b);
            wait_done((vt[i].b == '0) ? 2 : W + 1, 0);
        end

        // Start pulsed during the 3rd CALC cycle must be ignored.
        d0 = done_cnt;
        sb.push_back('{HQ, HR, 1'b0});
        issue(HA, HB);
        wait_done(W + 1, 3);
        repeat (10) @(negedge clk);
        chk("single_done_pulse", done_cnt - d0, 1);

        // Reset during the 4th CALC cycle aborts without a done pulse.
        d0 = done_cnt;
        issue(HA, HB);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero_outputs("abort");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_done_after_abort", done_cnt - d0, 0);

        sb.push_back('{RQ, RR, 1'b0});
        issue(RA, RB);
        wait_done(W + 1, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
